// File: rtl/ram_access_arbiter.sv
// Two-port arbiter sharing one single-port RAM between the SPI loader (port 0)
// and the processor (port 1); each access takes one IDLE and one ACCESS cycle.
module ram_access_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wdata,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                  state;
    logic                    last_grant;
    logic                    win;
    logic                    can_accept;
    logic                    lat_we;
    logic [ADDR_WIDTH-1:0]   lat_addr;
    logic [DATA_WIDTH-1:0]   lat_wdata;

    // win is the port that would be granted if it is requesting this cycle.
    always_comb begin
        win = 1'b0;
        if (req0_valid && req1_valid) begin
            if (FIXED_PRIO) win = 1'b0;
            else            win = ~last_grant;
        end else if (req1_valid) begin
            win = 1'b1;
        end
    end

    assign can_accept = (state == IDLE) && !rst;
    assign req0_ready = can_accept && req0_valid && !win;
    assign req1_ready = can_accept && req1_valid &&  win;

    // NOTE: rst gates the RAM strobes combinationally so a write caught in its
    // ACCESS cycle by reset is never committed at the following edge.
    assign ram_en    = (state == ACCESS) && !rst;
    assign ram_we    = ram_en && lat_we;
    assign ram_addr  = lat_addr;
    assign ram_wdata = lat_wdata;
    assign busy      = (state == ACCESS);

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            grant_id   <= 1'b0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_rdata <= '0;
            req1_rdata <= '0;
        end else begin
            req0_done <= 1'b0;
            req1_done <= 1'b0;
            if (state == IDLE) begin
                if (req0_ready || req1_ready) begin
                    lat_we     <= win ? req1_we    : req0_we;
                    lat_addr   <= win ? req1_addr  : req0_addr;
                    lat_wdata  <= win ? req1_wdata : req0_wdata;
                    last_grant <= win;
                    grant_id   <= win;
                    state      <= ACCESS;
                end
            end else begin
                // grant_id names the owner of the access completing now.
                if (grant_id) begin
                    req1_done <= 1'b1;
                    if (!lat_we) req1_rdata <= ram_rdata;
                end else begin
                    req0_done <= 1'b1;
                    if (!lat_we) req0_rdata <= ram_rdata;
                end
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomised bench for ram_access_arbiter: two instances (round-robin and fixed
// priority) with behavioural RAMs, checked against a transaction-level model.
module tb_ram_access_arbiter;

    typedef struct {
        logic        we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          delay;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  v0 = '0, we0 = '0, v1 = '0, we1 = '0;
    logic [7:0]  a0 [2], a1 [2];
    logic [31:0] wd0 [2], wd1 [2];
    logic [1:0]  rdy0, rdy1, dn0, dn1, en, wen, bsy, gid;
    logic [31:0] rd0 [2], rd1 [2], ram_wd [2], ram_rd [2];
    logic [7:0]  ram_a [2];
    logic [31:0] mem [2][256];
    logic [31:0] ref_mem [2][256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        ram_access_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .FIXED_PRIO(g == 1)) u_dut (
            .clk(clk), .rst(rst),
            .req0_valid(v0[g]), .req0_we(we0[g]), .req0_addr(a0[g]), .req0_wdata(wd0[g]),
            .req0_ready(rdy0[g]), .req0_done(dn0[g]), .req0_rdata(rd0[g]),
            .req1_valid(v1[g]), .req1_we(we1[g]), .req1_addr(a1[g]), .req1_wdata(wd1[g]),
            .req1_ready(rdy1[g]), .req1_done(dn1[g]), .req1_rdata(rd1[g]),
            .ram_en(en[g]), .ram_we(wen[g]), .ram_addr(ram_a[g]), .ram_wdata(ram_wd[g]),
            .ram_rdata(ram_rd[g]), .busy(bsy[g]), .grant_id(gid[g])
        );
        assign ram_rd[g] = mem[g][ram_a[g]];
    end

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int cur = 0;
    logic want_rst = 1'b1;

    req_t rq0[$];
    req_t rq1[$];

    logic        drv_v [2], drv_we [2];
    logic [7:0]  drv_a [2];
    logic [31:0] drv_wd [2];
    logic [1:0]  s_en = '0, s_we = '0, s_rdy = '0;
    logic [7:0]  s_a [2];
    logic [31:0] s_wd [2];

    // Transaction-level model: an accepted request occupies the RAM the next
    // cycle and completes two cycles after acceptance.
    logic        m_last = 1'b1, m_grant = 1'b0, m_pend = 1'b0;
    logic        m_pend_we, m_pend_port;
    int          m_pend_at;
    logic [7:0]  m_pend_addr;
    logic [31:0] m_pend_wdata, m_pend_data;
    logic [31:0] m_rdata [2];
    logic        exp_access;
    logic [111:0] exp_vec, obs_vec;

    task automatic model_cycle();
        logic       free, win;
        logic [1:0] done;
        int         p;
        done = '0;
        exp_access = m_pend && (cyc == m_pend_at - 1);
        if (m_pend && cyc == m_pend_at) begin
            done[m_pend_port] = 1'b1;
            if (m_pend_we) ref_mem[cur][m_pend_addr] = m_pend_wdata;
            else           m_rdata[m_pend_port] = m_pend_data;
            m_pend = 1'b0;
        end
        free = !rst && !exp_access;
        if (drv_v[0] && drv_v[1]) win = (cur == 1) ? 1'b0 : !m_last;
        else                      win = drv_v[0] ? 1'b0 : 1'b1;
        exp_vec = {free && drv_v[0] && !win, free && drv_v[1] && win, done[0], done[1],
                   exp_access && !rst, exp_access && m_pend_we && !rst, exp_access, m_grant,
                   m_rdata[0], m_rdata[1],
                   exp_access ? m_pend_addr : 8'h00, exp_access ? m_pend_wdata : 32'h0};
        if (free && (drv_v[0] || drv_v[1])) begin
            p = win ? 1 : 0;
            m_last = win; m_grant = win; m_pend = 1'b1; m_pend_at = cyc + 2;
            m_pend_port = win; m_pend_we = drv_we[p];
            m_pend_addr = drv_a[p]; m_pend_wdata = drv_wd[p];
            m_pend_data = ref_mem[cur][drv_a[p]];
        end
        if (rst) begin
            m_last = 1'b1; m_grant = 1'b0; m_pend = 1'b0;
            m_rdata[0] = '0; m_rdata[1] = '0;
        end
    endtask

    task automatic run_cycle();
        @(posedge clk);
        for (int g = 0; g < 2; g++)
            if (s_en[g] && s_we[g]) mem[g][s_a[g]] = s_wd[g];
        if (s_rdy[0] && rq0.size() > 0) void'(rq0.pop_front());
        if (s_rdy[1] && rq1.size() > 0) void'(rq1.pop_front());
        #1;
        rst = want_rst;
        for (int p = 0; p < 2; p++) begin
            drv_v[p] = 1'b0; drv_we[p] = 1'b0; drv_a[p] = '0; drv_wd[p] = '0;
        end
        if (rq0.size() > 0) begin
            if (rq0[0].delay > 0) rq0[0].delay = rq0[0].delay - 1;
            else begin drv_v[0] = 1'b1; drv_we[0] = rq0[0].we; drv_a[0] = rq0[0].addr; drv_wd[0] = rq0[0].wdata; end
        end
        if (rq1.size() > 0) begin
            if (rq1[0].delay > 0) rq1[0].delay = rq1[0].delay - 1;
            else begin drv_v[1] = 1'b1; drv_we[1] = rq1[0].we; drv_a[1] = rq1[0].addr; drv_wd[1] = rq1[0].wdata; end
        end
        for (int g = 0; g < 2; g++) begin
            v0[g]  = (g == cur) && drv_v[0];  we0[g] = (g == cur) && drv_we[0];
            a0[g]  = (g == cur) ? drv_a[0] : 8'h0;  wd0[g] = (g == cur) ? drv_wd[0] : 32'h0;
            v1[g]  = (g == cur) && drv_v[1];  we1[g] = (g == cur) && drv_we[1];
            a1[g]  = (g == cur) ? drv_a[1] : 8'h0;  wd1[g] = (g == cur) ? drv_wd[1] : 32'h0;
        end
        @(negedge clk);
        s_en = en; s_we = wen; s_rdy = {rdy1[cur], rdy0[cur]};
        for (int g = 0; g < 2; g++) begin s_a[g] = ram_a[g]; s_wd[g] = ram_wd[g]; end
        model_cycle();
        obs_vec = {rdy0[cur], rdy1[cur], dn0[cur], dn1[cur], en[cur], wen[cur], bsy[cur], gid[cur],
                   rd0[cur], rd1[cur],
                   exp_access ? ram_a[cur] : 8'h00, exp_access ? ram_wd[cur] : 32'h0};
        cyc++;
    endtask

    task automatic apply_reset();
        want_rst = 1'b1;
        repeat (2) run_cycle();
        want_rst = 1'b0;
    endtask

    task automatic test_reset();
        rq0.push_back('{we: 1'b0, addr: 8'h00, wdata: 32'h0, delay: 0});
        rq1.push_back('{we: 1'b0, addr: 8'h00, wdata: 32'h0, delay: 0});
        for (int i = 0; i < 3; i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_state cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            if ({en[0], ram_a[0], ram_wd[0]} !== 41'h0) begin
                miscompares++; $display("FAIL reset_ram got en=%b addr=%h wdata=%h exp all 0", en[0], ram_a[0], ram_wd[0]);
            end
            vectors++;
        end
        want_rst = 1'b0;
        run_cycle();
        if ({rdy0[0], rdy1[0]} !== 2'b10) begin
            miscompares++; $display("FAIL reset_first_grant got ready0/1=%b%b exp 10", rdy0[0], rdy1[0]);
        end
        vectors++;
        for (int i = 0; i < 20 && (rq0.size() > 0 || rq1.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL reset_drain cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
        end
    endtask

    task automatic test_write_read();
        int t_acc = -1, t_en = -1, t_done = -1;
        logic [31:0] got = '0;
        rq1.push_back('{we: 1'b1, addr: 8'h05, wdata: 32'hDEADBEEF, delay: 0});
        for (int i = 0; i < 20 && (rq1.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL write cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            if (rdy1[0]) t_acc = cyc;
            if (en[0] && wen[0] && ram_a[0] == 8'h05 && ram_wd[0] == 32'hDEADBEEF) t_en = cyc;
            if (dn1[0]) t_done = cyc;
        end
        if (t_acc < 0 || t_en != t_acc + 1 || t_done != t_acc + 2) begin
            miscompares++; $display("FAIL write_timing got acc=%0d en=%0d done=%0d exp en=acc+1 done=acc+2", t_acc, t_en, t_done);
        end
        vectors++;
        rq0.push_back('{we: 1'b0, addr: 8'h05, wdata: 32'h0, delay: 1});
        for (int i = 0; i < 20 && (rq0.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL readback cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            if (dn0[0]) got = rd0[0];
        end
        if (got !== 32'hDEADBEEF) begin
            miscompares++; $display("FAIL readback_data got %h exp deadbeef", got);
        end
        vectors++;
    endtask

    // Both ports stream reads; round-robin alternates, fixed priority drains port 0 first.
    task automatic test_arbitration(input int inst);
        int grants[$];
        int exp_g;
        cur = inst;
        apply_reset();
        for (int i = 0; i < 4; i++) begin
            rq0.push_back('{we: 1'b0, addr: 8'h01, wdata: $urandom, delay: 0});
            rq1.push_back('{we: 1'b0, addr: 8'h02, wdata: $urandom, delay: 0});
        end
        for (int i = 0; i < 60 && (rq0.size() > 0 || rq1.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL arb%0d cyc=%0d got=%h exp=%h", inst, cyc, obs_vec, exp_vec); end
            vectors++;
            if (rdy0[inst]) grants.push_back(0);
            if (rdy1[inst]) grants.push_back(1);
            if (inst == 1 && rdy1[1] && v0[1]) begin
                miscompares++; $display("FAIL fixed_starve cyc=%0d got ready1=1 with valid0=1 exp ready1=0", cyc);
            end
        end
        if (rq0.size() > 0 || rq1.size() > 0 || m_pend) begin
            miscompares++; $display("FAIL arb%0d_timeout got pending requests exp drained", inst);
        end
        if (grants.size() != 8) begin
            miscompares++; $display("FAIL arb%0d_count got %0d grants exp 8", inst, grants.size());
        end
        for (int i = 0; i < grants.size(); i++) begin
            exp_g = (inst == 0) ? (i % 2) : (i < 4 ? 0 : 1);
            if (grants[i] != exp_g) begin
                miscompares++; $display("FAIL arb%0d_order idx=%0d got %0d exp %0d", inst, i, grants[i], exp_g);
            end
            vectors++;
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int dn[$];
        cur = 0;
        apply_reset();
        for (int i = 0; i < 3; i++)
            rq1.push_back('{we: 1'b0, addr: i[7:0], wdata: 32'h0, delay: 0});
        for (int i = 0; i < 20 && (rq1.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            if (rdy1[0]) acc.push_back(cyc);
            if (dn1[0]) begin
                dn.push_back(cyc);
                if (rd1[0] !== mem[0][dn.size() - 1]) begin
                    miscompares++; $display("FAIL b2b_data got %h exp %h", rd1[0], mem[0][dn.size() - 1]);
                end
                vectors++;
            end
        end
        if (acc.size() != 3 || dn.size() != 3) begin
            miscompares++; $display("FAIL b2b_count got acc=%0d done=%0d exp 3/3", acc.size(), dn.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (acc[i] - acc[0] != 2 * i || dn[i] - acc[0] != 2 * i + 2) begin
                    miscompares++; $display("FAIL b2b_timing idx=%0d got acc=%0d done=%0d exp %0d/%0d",
                                            i, acc[i] - acc[0], dn[i] - acc[0], 2 * i, 2 * i + 2);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] old;
        logic got_acc = 1'b0, saw_done = 1'b0;
        cur = 0;
        apply_reset();
        old = mem[0][8'h10];
        rq0.push_back('{we: 1'b1, addr: 8'h10, wdata: ~old, delay: 0});
        for (int i = 0; i < 10 && !got_acc; i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL abort_req cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            got_acc = rdy0[0];
        end
        want_rst = 1'b1;
        run_cycle();
        if ({en[0], wen[0]} !== 2'b00) begin
            miscompares++; $display("FAIL abort_strobe got en/we=%b%b exp 00", en[0], wen[0]);
        end
        vectors++;
        run_cycle();
        want_rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL abort_after cyc=%0d got=%h exp=%h", cyc, obs_vec, exp_vec); end
            vectors++;
            if (dn0[0]) saw_done = 1'b1;
        end
        if (saw_done || mem[0][8'h10] !== old) begin
            miscompares++; $display("FAIL abort_commit got done=%b mem=%h exp done=0 mem=%h", saw_done, mem[0][8'h10], old);
        end
        vectors++;
        rq1.push_back('{we: 1'b0, addr: 8'h10, wdata: 32'h0, delay: 0});
        run_cycle();
        if (rdy1[0] !== 1'b1) begin
            miscompares++; $display("FAIL abort_idle got ready1=%b exp 1", rdy1[0]);
        end
        vectors++;
        for (int i = 0; i < 10 && (rq1.size() > 0 || m_pend); i++) run_cycle();
    endtask

    task automatic test_random(input int inst);
        cur = inst;
        apply_reset();
        for (int i = 0; i < 30; i++) begin
            rq0.push_back('{we: 1'($urandom), addr: 8'($urandom_range(0, 15)), wdata: $urandom, delay: $urandom_range(0, 3)});
            rq1.push_back('{we: 1'($urandom), addr: 8'($urandom_range(0, 15)), wdata: $urandom, delay: $urandom_range(0, 3)});
        end
        for (int i = 0; i < 1000 && (rq0.size() > 0 || rq1.size() > 0 || m_pend); i++) begin
            run_cycle();
            if (obs_vec !== exp_vec) begin miscompares++; $display("FAIL random%0d cyc=%0d got=%h exp=%h", inst, cyc, obs_vec, exp_vec); end
            vectors++;
        end
        if (rq0.size() > 0 || rq1.size() > 0 || m_pend) begin
            miscompares++; $display("FAIL random%0d_timeout got pending requests exp drained", inst);
        end
        run_cycle();
        for (int a = 0; a < 16; a++) begin
            if (mem[inst][a] !== ref_mem[inst][a]) begin
                miscompares++; $display("FAIL random%0d_mem addr=%0d got %h exp %h", inst, a, mem[inst][a], ref_mem[inst][a]);
            end
            vectors++;
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            a0[g] = '0; a1[g] = '0; wd0[g] = '0; wd1[g] = '0; s_a[g] = '0; s_wd[g] = '0;
            m_rdata[g] = '0;
            for (int i = 0; i < 256; i++) begin
                mem[g][i] = $urandom;
                ref_mem[g][i] = mem[g][i];
            end
        end
        test_reset();
        test_write_read();
        test_arbitration(0);
        test_arbitration(1);
        test_back_to_back();
        test_reset_abort();
        test_random(0);
        test_random(1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Two-requester arbiter that shares the single-port program/data RAM between the SPI loader (port 0) and the processor core (port 1). Each requester issues a valid/ready request; the arbiter serialises requests onto the RAM's flat en/we/addr/wdata/rdata port and returns read data or write completion to the owning requester. The block sits between the SPI front-end, the processor and the RAM instance in the top level.

Parameters:
ADDR_WIDTH, 8, RAM word-address width
DATA_WIDTH, 32, RAM word width
FIXED_PRIO, 0, 0 = round-robin between ports; 1 = port 0 always wins on conflict

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req0_valid  in  1  port 0 (SPI loader) request valid
req0_we  in  1  port 0: 1 = write, 0 = read
req0_addr  in  ADDR_WIDTH  port 0 word address
req0_wdata  in  DATA_WIDTH  port 0 write data
req0_ready  out  1  port 0 request accepted this cycle (valid && ready)
req0_done  out  1  port 0 one-cycle completion pulse (read data valid, or write committed)
req0_rdata  out  DATA_WIDTH  port 0 read data, valid while req0_done=1
req1_valid, req1_we, req1_addr, req1_wdata, req1_ready, req1_done, req1_rdata  same as port 0, for the processor
ram_en  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM read data (combinational from ram_addr)
busy  out  1  1 while state is ACCESS
grant_id  out  1  port that owns the current or most recent access

Behaviour:
- States: IDLE, ACCESS. Reset: state=IDLE, last-grant pointer=1 (port 0 wins the first conflict), grant_id=0, all readyN=0, doneN=0, rdataN=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, busy=0.
- rst is sampled at clk only. While rst=1, ram_en and ram_we are forced 0 combinationally. An access in flight when rst asserts is dropped: no write is committed and no done pulse is issued.
- IDLE: readyN is combinational. It is asserted for at most one port, the arbitration winner among ports with validN=1.
  - Only one valid: that port wins.
  - Both valid, FIXED_PRIO=0: the port not equal to the last-grant pointer wins.
  - Both valid, FIXED_PRIO=1: port 0 wins.
- On acceptance at edge T:
  - Latch we/addr/wdata and the port id into internal registers.
  - Update the last-grant pointer and grant_id to the winner.
  - Move to ACCESS.
- ACCESS (cycle T+1):
  - ram_en=1; ram_we, ram_addr and ram_wdata are driven from the latches; busy=1; both readyN=0.
  - At the end of the cycle, ram_rdata is captured into rdataN of the owner. For a write, the owner's rdataN holds its previous value.
  - The write commits at this edge.
  - Next state is IDLE.
- Cycle T+2: doneN=1 for exactly one cycle on the owner. A new request may be accepted in the same cycle (back-to-back throughput is one access per 2 cycles).
- ram_en=0 in IDLE. ram_addr and ram_wdata hold their last latched values.
- Requesters must hold valid/we/addr/wdata stable until ready. The arbiter ignores changes after acceptance.
- The non-owner's doneN stays 0 and its rdataN is unchanged.
- validN with no grant (losing a conflict) stalls with readyN=0. With FIXED_PRIO=0, no port waits more than one access.

Test Plan:
- Reset: hold rst 3 cycles with both valid=1 -> all outputs 0, no ram_en. First cycle after release, both valid -> req0_ready=1, req1_ready=0.
- Port 1 write addr 0x05 data 0xDEADBEEF accepted at T -> ram_en=ram_we=1, ram_addr=0x05 at T+1. req1_done=1 at T+2. A later port 0 read of 0x05 returns req0_rdata=0xDEADBEEF with req0_done=1.
- Both ports continuously reading (port 0 addr 0x01, port 1 addr 0x02), FIXED_PRIO=0 -> grants alternate 0,1,0,1. Each done pulses every 4 cycles with correct data, and done never appears on the wrong port.
- Same stimulus with FIXED_PRIO=1 -> port 0 granted every access. req1_ready is never asserted while req0_valid=1.
- Back-to-back: port 1 issues reads to 0x00, 0x01, 0x02 with valid held -> accepts on cycles 0,2,4, done on 2,4,6, rdata matching the RAM contents.
- rst asserted during the ACCESS cycle of a port 0 write to 0x10 -> the RAM location keeps its old value, no req0_done, state IDLE after reset.
